project_switch_sequencer: RTL and testbench
===========================================

# project_switch_sequencer

Controls switching between harness projects so that a change is glitch-free. It sits directly upstream of the harness IO mux. It accepts a project-select request from the Wishbone decode, isolates the pads, holds the incoming project in reset, and then hands the pads to that project. The IO mux uses its `active_project` and `io_isolate` outputs in place of a raw register. Every project reset is driven from `project_reset`.

## Interface

Parameters:
- `NUM_PROJECTS`, 5: number of selectable projects; valid ids are 0..NUM_PROJECTS-1.
- `SETTLE_CYCLES`, 16: cycles the pads stay isolated before the new project is reset; minimum 1.
- `RESET_CYCLES`, 8: cycles the new project is held in reset; minimum 1.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `reset_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  project-change request.
- `req_project`  in  8  requested project id.
- `req_ready`  out  1  request accepted when `req_valid` and `req_ready` are both high.
- `active_project`  out  8  project currently routed to the pads.
- `io_isolate`  out  1  when high, the mux forces `io_out`=0 and `io_oeb` all-ones.
- `project_reset`  out  NUM_PROJECTS  per-project reset, active-high.
- `busy`  out  1  high whenever the state is not IDLE.
- `err_invalid`  out  1  one-cycle pulse when a request with an out-of-range id is accepted.
- `switch_count`  out  16  count of completed switches (see Configuration).

## Operation

- States: RESET, ISOLATE, RELEASE, IDLE. A down-counter is shared by ISOLATE and RESET and is sized for the larger parameter.
- Sampling `reset_n` low forces the following, overriding any in-progress sequence:
  - state=RESET, `active_project`=0;
  - `io_isolate`=1, `project_reset`=all-ones;
  - `err_invalid`=0, `switch_count`=0, counter=RESET_CYCLES-1.
- `req_ready` = (state==IDLE). `busy` = !`req_ready`.
- IDLE:
  - A request with `req_project` < NUM_PROJECTS is accepted, latched as the target, and moves the state to ISOLATE with counter=SETTLE_CYCLES-1.
  - An accepted request with `req_project` >= NUM_PROJECTS pulses `err_invalid`, stays in IDLE and changes nothing else.
  - A request for the already-active id runs the full sequence; this is how software re-resets a project.
- ISOLATE: `io_isolate`=1; `active_project` and `project_reset` are unchanged. When counter==0, `active_project` is set to the target, `project_reset` to all-ones, counter to RESET_CYCLES-1, and the state moves to RESET.
- RESET: `io_isolate`=1 and `project_reset`=all-ones. When counter==0 the state moves to RELEASE.
- RELEASE, one cycle: `project_reset`[active]=0 and all other bits 1; `io_isolate`=1; the counter increments (Configuration); the state moves to IDLE.
- IDLE: `io_isolate`=0 and `project_reset`[active]=0; every non-active project stays in reset.
- `req_valid` during a non-IDLE state is ignored and not queued; the requester holds it until `req_ready`.
- `req_project` is compared at the full 8 bits; bits are never truncated.

## Timing

- A request accepted on edge t gives:
  - ISOLATE for cycles t+1..t+SETTLE_CYCLES;
  - RESET for the next RESET_CYCLES cycles;
  - RELEASE for one cycle;
  - IDLE, with `io_isolate`=0 and `req_ready`=1, at t+SETTLE_CYCLES+RESET_CYCLES+2. With defaults this is t+26.
- `active_project` changes on the edge that enters RESET, so it never changes while `io_isolate`=0.
- After `reset_n` rises: RESET for RESET_CYCLES cycles, then RELEASE, then IDLE at cycle RESET_CYCLES+1 with project 0 live.
- `err_invalid` is asserted in the cycle after acceptance, for exactly one cycle.
- All outputs are registered; there is no combinational path from any input to any output except `req_ready`, which depends on state only.

## Configuration

- Macro: `PROJECT_SWITCH_COUNT_EN`.
- Defined:
  - `switch_count` is a 16-bit counter, incremented in RELEASE and saturating at 16'hFFFF.
  - Boot RELEASE does not increment it.
  - It is cleared by reset.
- Undefined: `switch_count` is tied to 0 and no counter flops exist.

## Test plan

- Boot: hold `reset_n` low for 3 cycles, then release → `project_reset`=5'b11111 for 8 cycles, RELEASE leaves 5'b11110, `req_ready`=1 at cycle 9, `active_project`=0.
- Switch 0→2 accepted at edge t:
  - `io_isolate`=1 from t+1;
  - `active_project`=2 at t+17;
  - `project_reset`=5'b11011 at t+25;
  - `io_isolate`=0 at t+26;
  - `switch_count`=1 (macro defined).
- Invalid id 7 → `err_invalid` high for exactly 1 cycle, `active_project` and `io_isolate` unchanged, `req_ready` stays 1.
- Busy rejection: request 3, then request 1 held from t+5 → `req_ready`=0 until t+26; 1 is accepted at t+26 and `active_project`=1 at t+43.
- Same-id request 2→2 → full 26-cycle sequence, `project_reset`[2]=1 during RESET, `switch_count` increments.
- Mid-switch reset: `reset_n` low at t+20 of a 0→4 switch → next cycle `active_project`=0, state RESET, `switch_count`=0; boot timing repeats.

Source files
------------

// File: rtl/project_switch_sequencer.sv
// ============================================================================
// Module   : project_switch_sequencer
// Purpose  : Glitch-free project switching ahead of the harness IO mux.
//            Isolates the pads, holds the incoming project in reset, then
//            releases it and hands it the pads.
// Options  : PROJECT_SWITCH_COUNT_EN - when defined, switch_count counts
//            completed switches (saturating); otherwise it is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module project_switch_sequencer #(
    parameter int NUM_PROJECTS  = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int RESET_CYCLES  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    input  logic [7:0]              req_project,
    output logic                    req_ready,
    output logic [7:0]              active_project,
    output logic                    io_isolate,
    output logic [NUM_PROJECTS-1:0] project_reset,
    output logic                    busy,
    output logic                    err_invalid,
    output logic [15:0]             switch_count
);

    // Shared down-counter is sized for whichever wait is longer.
    localparam int c_CNT_MAX = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RESET_LOAD  = c_CNT_W'(RESET_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [8:0]         c_NUM_PROJ    = 9'(NUM_PROJECTS);

    localparam logic [1:0] c_ST_RESET   = 2'd0;
    localparam logic [1:0] c_ST_ISOLATE = 2'd1;
    localparam logic [1:0] c_ST_RELEASE = 2'd2;
    localparam logic [1:0] c_ST_IDLE    = 2'd3;

    logic [1:0]              r_state;
    logic [c_CNT_W-1:0]      r_count;
    logic [7:0]              r_target;
    logic [7:0]              r_active_project;
    logic                    r_io_isolate;
    logic [NUM_PROJECTS-1:0] r_project_reset;
    logic                    r_err_invalid;

    logic [1:0]              w_state;
    logic [c_CNT_W-1:0]      w_count;
    logic [7:0]              w_target;
    logic [7:0]              w_active_project;
    logic                    w_io_isolate;
    logic [NUM_PROJECTS-1:0] w_project_reset;
    logic                    w_err_invalid;

    logic [NUM_PROJECTS-1:0] w_active_onehot;
    logic                    w_req_in_range;

    // One-hot of the currently routed project; its reset bit is the one released.
    generate
        for (genvar gi = 0; gi < NUM_PROJECTS; gi++) begin : g_onehot
            assign w_active_onehot[gi] = (r_active_project == 8'(gi));
        end
    endgenerate

    // Full 8-bit compare so out-of-range ids never alias onto valid ones.
    assign w_req_in_range = ({1'b0, req_project} < c_NUM_PROJ);

    // Next-state and next-output logic; registered outputs track the state being entered.
    always_comb begin
        w_state          = r_state;
        w_count          = r_count;
        w_target         = r_target;
        w_active_project = r_active_project;
        w_io_isolate     = r_io_isolate;
        w_project_reset  = r_project_reset;
        w_err_invalid    = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_io_isolate    = 1'b0;
                w_project_reset = ~w_active_onehot;
                if (req_valid) begin
                    if (w_req_in_range) begin
                        w_state      = c_ST_ISOLATE;
                        w_count      = c_SETTLE_LOAD;
                        w_target     = req_project;
                        w_io_isolate = 1'b1;
                    end else begin
                        w_err_invalid = 1'b1;
                    end
                end
            end
            c_ST_ISOLATE: begin
                w_io_isolate = 1'b1;
                if (r_count == '0) begin
                    // Pads are already isolated, so the route can change here safely.
                    w_state          = c_ST_RESET;
                    w_count          = c_RESET_LOAD;
                    w_active_project = r_target;
                    w_project_reset  = '1;
                end else begin
                    w_count = r_count - c_CNT_ONE;
                end
            end
            c_ST_RESET: begin
                w_io_isolate    = 1'b1;
                w_project_reset = '1;
                if (r_count == '0) begin
                    w_state         = c_ST_RELEASE;
                    w_project_reset = ~w_active_onehot;
                end else begin
                    w_count = r_count - c_CNT_ONE;
                end
            end
            c_ST_RELEASE: begin
                w_state         = c_ST_IDLE;
                w_io_isolate    = 1'b0;
                w_project_reset = ~w_active_onehot;
            end
            default: begin
                w_state = c_ST_RESET;
            end
        endcase
    end

    // State and output registers; reset restarts the boot sequence on project 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state          <= c_ST_RESET;
            r_count          <= c_RESET_LOAD;
            r_target         <= 8'd0;
            r_active_project <= 8'd0;
            r_io_isolate     <= 1'b1;
            r_project_reset  <= '1;
            r_err_invalid    <= 1'b0;
        end else begin
            r_state          <= w_state;
            r_count          <= w_count;
            r_target         <= w_target;
            r_active_project <= w_active_project;
            r_io_isolate     <= w_io_isolate;
            r_project_reset  <= w_project_reset;
            r_err_invalid    <= w_err_invalid;
        end
    end

`ifdef PROJECT_SWITCH_COUNT_EN
    logic [15:0] r_switch_count;
    logic        r_boot_release;

    // Count completed switches; the first RELEASE after reset is the boot release and is skipped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_switch_count <= 16'h0000;
            r_boot_release <= 1'b1;
        end else if (r_state == c_ST_RELEASE) begin
            r_boot_release <= 1'b0;
            if (!r_boot_release && (r_switch_count != 16'hFFFF)) begin
                r_switch_count <= r_switch_count + 16'd1;
            end
        end
    end

    assign switch_count = r_switch_count;
`else
    assign switch_count = 16'h0000;
`endif

    assign req_ready      = (r_state == c_ST_IDLE);
    assign busy           = (r_state != c_ST_IDLE);
    assign active_project = r_active_project;
    assign io_isolate     = r_io_isolate;
    assign project_reset  = r_project_reset;
    assign err_invalid    = r_err_invalid;

endmodule

`default_nettype wire

// File: tb/tb_project_switch_sequencer.sv
// ============================================================================
// Module   : tb_project_switch_sequencer
// Purpose  : Self-checking bench for project_switch_sequencer. A timeline
//            model predicts every output each cycle; directed steps add
//            literal checks at the key instants of each scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_project_switch_sequencer;

    localparam int c_NP     = 5;
    localparam int c_SETTLE = 16;
    localparam int c_RESET  = 8;

`ifdef PROJECT_SWITCH_COUNT_EN
    localparam bit c_CNT_EN = 1'b1;
`else
    localparam bit c_CNT_EN = 1'b0;
`endif

    localparam int c_MODE_BOOT   = 0;
    localparam int c_MODE_SWITCH = 1;
    localparam int c_MODE_IDLE   = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic [7:0]        req_project;
    logic              req_ready;
    logic [7:0]        active_project;
    logic              io_isolate;
    logic [c_NP-1:0]   project_reset;
    logic              busy;
    logic              err_invalid;
    logic [15:0]       switch_count;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    project_switch_sequencer #(
        .NUM_PROJECTS  (c_NP),
        .SETTLE_CYCLES (c_SETTLE),
        .RESET_CYCLES  (c_RESET)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_project    (req_project),
        .req_ready      (req_ready),
        .active_project (active_project),
        .io_isolate     (io_isolate),
        .project_reset  (project_reset),
        .busy           (busy),
        .err_invalid    (err_invalid),
        .switch_count   (switch_count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [c_NP-1:0] onehot(input logic [7:0] a);
        logic [c_NP-1:0] v;
        for (int i = 0; i < c_NP; i++) v[i] = (int'(a) == i);
        return v;
    endfunction

    // Timeline model: m_k counts edges since the sequence began (boot or acceptance).
    int          m_mode    = c_MODE_BOOT;
    int          m_k       = 0;
    logic [7:0]  m_active  = 8'd0;
    logic [7:0]  m_target  = 8'd0;
    logic        m_err     = 1'b0;
    logic [15:0] m_cnt     = 16'd0;
    logic        m_started = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_started <= 1'b1;
            m_mode    <= c_MODE_BOOT;
            m_k       <= 0;
            m_active  <= 8'd0;
            m_err     <= 1'b0;
            m_cnt     <= 16'd0;
        end else begin
            m_err <= 1'b0;
            if (m_mode == c_MODE_BOOT) begin
                if (m_k == c_RESET) m_mode <= c_MODE_IDLE;
                else                m_k    <= m_k + 1;
            end else if (m_mode == c_MODE_SWITCH) begin
                if (m_k == c_SETTLE + c_RESET) begin
                    m_mode   <= c_MODE_IDLE;
                    m_active <= m_target;
                    if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (req_valid) begin
                if (int'(req_project) < c_NP) begin
                    m_mode   <= c_MODE_SWITCH;
                    m_k      <= 0;
                    m_target <= req_project;
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [7:0]      e_active;
        logic            e_iso;
        logic [c_NP-1:0] e_prst;
        logic            e_ready;
        logic [15:0]     e_cnt;
        if (m_started) begin
            e_ready = (m_mode == c_MODE_IDLE);
            if (m_mode == c_MODE_BOOT) begin
                e_active = 8'd0;
                e_iso    = 1'b1;
                e_prst   = (m_k < c_RESET) ? '1 : ~onehot(8'd0);
            end else if (m_mode == c_MODE_SWITCH) begin
                e_iso    = 1'b1;
                e_active = (m_k >= c_SETTLE) ? m_target : m_active;
                if (m_k < c_SETTLE)                e_prst = ~onehot(m_active);
                else if (m_k < c_SETTLE + c_RESET) e_prst = '1;
                else                               e_prst = ~onehot(m_target);
            end else begin
                e_iso    = 1'b0;
                e_active = m_active;
                e_prst   = ~onehot(m_active);
            end
            e_cnt = c_CNT_EN ? m_cnt : 16'd0;
            check("model_req_ready",      32'(req_ready),      32'(e_ready));
            check("model_busy",           32'(busy),           32'(!e_ready));
            check("model_active_project", 32'(active_project), 32'(e_active));
            check("model_io_isolate",     32'(io_isolate),     32'(e_iso));
            check("model_project_reset",  32'(project_reset),  32'(e_prst));
            check("model_err_invalid",    32'(err_invalid),    32'(m_err));
            check("model_switch_count",   32'(switch_count),   32'(e_cnt));
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a request for one edge; returns just after the accepting edge.
    task automatic req(input logic [7:0] p);
        req_valid   = 1'b1;
        req_project = p;
        @(negedge clk);
        req_valid   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_project = 8'd0;

        // Boot
        wait_n(3);
        reset_n = 1'b1;
        wait_n(1);
        check("boot_prst_held",   32'(project_reset), 32'h1F);
        check("boot_isolated",    32'(io_isolate),    32'h1);
        wait_n(7);
        check("boot_release_prst", 32'(project_reset), 32'h1E);
        check("boot_release_busy", 32'(req_ready),     32'h0);
        wait_n(1);
        check("boot_ready",  32'(req_ready),      32'h1);
        check("boot_active", 32'(active_project), 32'h0);
        check("boot_io_live", 32'(io_isolate),    32'h0);

        // Switch 0 -> 2
        req(8'd2);
        check("sw02_iso_start", 32'(io_isolate), 32'h1);
        wait_n(15);
        check("sw02_active_old", 32'(active_project), 32'h0);
        wait_n(1);
        check("sw02_active_new", 32'(active_project), 32'h2);
        check("sw02_prst_all",   32'(project_reset),  32'h1F);
        wait_n(8);
        check("sw02_release_prst", 32'(project_reset), 32'h1B);
        wait_n(1);
        check("sw02_io_live", 32'(io_isolate),   32'h0);
        check("sw02_ready",   32'(req_ready),    32'h1);
        check("sw02_count",   32'(switch_count), c_CNT_EN ? 32'h1 : 32'h0);

        // Invalid ids, including one that would alias if truncated
        req(8'd7);
        check("inv7_err",    32'(err_invalid),    32'h1);
        check("inv7_active", 32'(active_project), 32'h2);
        check("inv7_iso",    32'(io_isolate),     32'h0);
        check("inv7_ready",  32'(req_ready),      32'h1);
        wait_n(1);
        check("inv7_err_pulse", 32'(err_invalid), 32'h0);
        req(8'd5);
        check("inv5_err", 32'(err_invalid), 32'h1);
        req(8'h82);
        check("inv82_err",   32'(err_invalid), 32'h1);
        check("inv82_ready", 32'(req_ready),   32'h1);
        wait_n(1);

        // Busy rejection: 3 accepted, 1 held from t+5 until accepted at t+26
        req(8'd3);
        wait_n(4);
        req_valid   = 1'b1;
        req_project = 8'd1;
        wait_n(21);
        check("busy_ready_t25", 32'(req_ready),      32'h1);
        check("busy_active_3",  32'(active_project), 32'h3);
        wait_n(1);
        check("busy_accept_1", 32'(req_ready), 32'h0);
        req_valid = 1'b0;
        wait_n(15);
        check("busy_active_still3", 32'(active_project), 32'h3);
        wait_n(1);
        check("busy_active_1", 32'(active_project), 32'h1);
        wait_n(9);
        check("busy_done_ready", 32'(req_ready), 32'h1);

        // Move to 2, then re-reset 2
        req(8'd2);
        wait_n(25);
        req(8'd2);
        wait_n(16);
        check("same_prst_all", 32'(project_reset),  32'h1F);
        check("same_active",   32'(active_project), 32'h2);
        wait_n(8);
        check("same_release_prst", 32'(project_reset), 32'h1B);
        wait_n(1);
        check("same_ready", 32'(req_ready),    32'h1);
        check("same_count", 32'(switch_count), c_CNT_EN ? 32'h5 : 32'h0);

        // Mid-switch reset during 2 -> 4
        req(8'd4);
        wait_n(19);
        reset_n = 1'b0;
        wait_n(1);
        check("midrst_active", 32'(active_project), 32'h0);
        check("midrst_busy",   32'(req_ready),      32'h0);
        check("midrst_count",  32'(switch_count),   32'h0);
        check("midrst_prst",   32'(project_reset),  32'h1F);
        reset_n = 1'b1;
        wait_n(8);
        check("midrst_release_prst", 32'(project_reset), 32'h1E);
        wait_n(1);
        check("midrst_ready",  32'(req_ready),      32'h1);
        check("midrst_active0", 32'(active_project), 32'h0);
        wait_n(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
